// File: rtl/coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : coin_pulse_conditioner
// Purpose  : Synchronises and debounces two coin sensors and emits one clean
//            1-cycle pulse per accepted coin. Optional jam detection is built
//            when JAM_DETECT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module coin_pulse_conditioner #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5,
    parameter int JAM_CYCLES = 1000,
    parameter int JAM_W      = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic coin_a_raw,
    input  logic coin_b_raw,
    output logic a_out,
    output logic b_out,
    output logic jam
);

    localparam logic [DEB_W-1:0] c_deb_max = DEB_W'(DEB_CYCLES);

    if ((DEB_CYCLES < 2) || (DEB_CYCLES > (2**DEB_W) - 1) ||
        (JAM_CYCLES < 2) || (JAM_CYCLES > (2**JAM_W) - 1)) begin : g_param_check
        $error("coin_pulse_conditioner: counter parameter out of range");
    end

    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic [1:0] w_lvl;
    logic       w_jam_now;

    assign w_raw = {coin_b_raw, coin_a_raw};

    // Channel 0 is the 1-yuan slot, channel 1 the 0.5-yuan slot.
    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic             r_s1;
        logic             r_s2;
        logic             r_lvl;
        logic [DEB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_lvl <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[i];
                r_s2 <= r_s1;
                if (r_s2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_max) begin
                    r_lvl <= ~r_lvl;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Level flips once DEB_CYCLES mismatches are banked and the input still disagrees.
        assign w_rise[i] = r_s2 && !r_lvl && (r_cnt == c_deb_max);
        assign w_lvl[i]  = r_lvl;
    end

`ifdef JAM_DETECT_EN
    localparam logic [JAM_W-1:0] c_jam_last = JAM_W'(JAM_CYCLES - 1);

    logic [1:0] w_jam_hit;
    logic       r_jam;

    for (genvar j = 0; j < 2; j++) begin : g_jam
        logic [JAM_W-1:0] r_jcnt;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_jcnt <= '0;
            end else if (!w_lvl[j]) begin
                r_jcnt <= '0;
            end else if (r_jcnt != c_jam_last) begin
                r_jcnt <= r_jcnt + 1'b1;
            end
        end

        assign w_jam_hit[j] = w_lvl[j] && (r_jcnt == c_jam_last);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_jam <= 1'b0;
        end else if (|w_jam_hit) begin
            r_jam <= 1'b1;
        end
    end

    assign w_jam_now = r_jam;
`else
    assign w_jam_now = 1'b0;
`endif

    logic r_pend_a;
    logic r_pend_b;
    logic r_a_out;
    logic r_b_out;

    // A served flag is cleared unless a new event lands on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_a_out  <= 1'b0;
            r_b_out  <= 1'b0;
        end else if (w_jam_now) begin
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_a_out  <= 1'b0;
            r_b_out  <= 1'b0;
        end else begin
            r_a_out  <= r_pend_a;
            r_b_out  <= !r_pend_a && r_pend_b;
            r_pend_a <= w_rise[0];
            r_pend_b <= w_rise[1] || (r_pend_b && r_pend_a);
        end
    end

    assign a_out = r_a_out;
    assign b_out = r_b_out;
    assign jam   = w_jam_now;

endmodule
`default_nettype wire

// File: tb/tb_coin_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_pulse_conditioner
// Purpose  : Directed bench for coin_pulse_conditioner with a cycle-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_coin_pulse_conditioner;

    localparam int DEB = 4;
    localparam int JAM = 20;

    logic clk        = 1'b0;
    logic rstn       = 1'b1;
    logic coin_a_raw = 1'b0;
    logic coin_b_raw = 1'b0;
    logic a_out;
    logic b_out;
    logic jam;

    always #5 clk = ~clk;

    coin_pulse_conditioner #(
        .DEB_CYCLES (DEB),
        .DEB_W      (5),
        .JAM_CYCLES (JAM),
        .JAM_W      (10)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .coin_a_raw (coin_a_raw),
        .coin_b_raw (coin_b_raw),
        .a_out      (a_out),
        .b_out      (b_out),
        .jam        (jam)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    bit [1:0]  ms1, ms2, mlvl;
    bit [15:0] hist [2];
    int        rise_t [2];
    int        m_t = 0;
    int        pa = 0, pb = 0;
    bit        m_a, m_b, m_jam;

    int na = 0, nb = 0, ea = -1, eb = -1, jam_edge = -1;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    endtask

    // Model of one rising edge, from the rules: 2-stage sync, a level flips after
    // DEB+1 consecutive disagreeing samples, rises queue a pulse, A has priority.
    task automatic model_step();
        bit       jp;
        bit       s;
        bit       all_diff;
        bit [1:0] raw;
        raw = {coin_b_raw, coin_a_raw};
        if (!rstn) begin
            ms1 = '0; ms2 = '0; mlvl = '0;
            hist[0] = '0; hist[1] = '0;
            rise_t[0] = 0; rise_t[1] = 0;
            pa = 0; pb = 0; m_a = 0; m_b = 0; m_jam = 0;
        end else begin
            m_t++;
            jp  = m_jam;
            m_a = 0;
            m_b = 0;
            if (jp) begin
                pa = 0; pb = 0;
            end else if (pa > 0) begin
                m_a = 1; pa--;
            end else if (pb > 0) begin
                m_b = 1; pb--;
            end
            for (int ch = 0; ch < 2; ch++) begin
                s       = ms2[ch];
                ms2[ch] = ms1[ch];
                ms1[ch] = raw[ch];
                hist[ch] = {hist[ch][14:0], s};
                all_diff = 1;
                for (int k = 0; k <= DEB; k++)
                    if (hist[ch][k] == mlvl[ch]) all_diff = 0;
`ifdef JAM_DETECT_EN
                if (mlvl[ch] && (m_t - rise_t[ch] == JAM)) m_jam = 1;
`endif
                if (all_diff) begin
                    mlvl[ch] = ~mlvl[ch];
                    if (mlvl[ch]) begin
                        rise_t[ch] = m_t;
                        if (!jp) begin
                            if (ch == 0) pa++;
                            else pb++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model_step();
        chk("a_out", int'(a_out), int'(m_a));
        chk("b_out", int'(b_out), int'(m_b));
        chk("jam", int'(jam), int'(m_jam));
        chk("a_b_exclusive", int'(a_out & b_out), 0);
        if (a_out === 1'b1) begin na++; ea = cyc; end
        if (b_out === 1'b1) begin nb++; eb = cyc; end
        if (jam === 1'b1 && jam_edge < 0) jam_edge = cyc;
    endtask

    initial begin
        int t0, na0, nb0;

        #1 rstn = 1'b0;
        repeat (3) tick();
        chk("reset_a_out", int'(a_out), 0);
        chk("reset_b_out", int'(b_out), 0);
        chk("reset_jam", int'(jam), 0);
        rstn = 1'b1;
        repeat (3) tick();

        // 1: lone 1-yuan coin
        na0 = na; nb0 = nb;
        coin_a_raw = 1'b1; t0 = cyc + 1;
        repeat (10) tick();
        coin_a_raw = 1'b0;
        repeat (20) tick();
        chk("t1_a_count", na - na0, 1);
        chk("t1_a_latency", ea - t0, 7);
        chk("t1_b_count", nb - nb0, 0);

        // 2: chatter then settle high
        na0 = na;
        for (int i = 0; i < 12; i++) begin
            coin_a_raw = (i % 2 == 0);
            tick();
        end
        coin_a_raw = 1'b1; t0 = cyc + 1;
        repeat (12) tick();
        coin_a_raw = 1'b0;
        repeat (20) tick();
        chk("t2_a_count", na - na0, 1);
        chk("t2_a_latency", ea - t0, 7);

        // 3: simultaneous coins
        na0 = na; nb0 = nb;
        coin_a_raw = 1'b1; coin_b_raw = 1'b1; t0 = cyc + 1;
        repeat (10) tick();
        coin_a_raw = 1'b0; coin_b_raw = 1'b0;
        repeat (20) tick();
        chk("t3_a_count", na - na0, 1);
        chk("t3_b_count", nb - nb0, 1);
        chk("t3_a_latency", ea - t0, 7);
        chk("t3_b_latency", eb - t0, 8);

        // 4: short b bursts, only the long one is accepted
        na0 = na; nb0 = nb;
        coin_b_raw = 1'b1; repeat (3) tick();
        coin_b_raw = 1'b0; repeat (3) tick();
        coin_b_raw = 1'b1; t0 = cyc + 1;
        repeat (8) tick();
        coin_b_raw = 1'b0;
        repeat (20) tick();
        chk("t4_b_count", nb - nb0, 1);
        chk("t4_b_latency", eb - t0, 7);
        chk("t4_a_count", na - na0, 0);

        // 5: coin lost to reset
        na0 = na;
        coin_a_raw = 1'b1;
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        chk("t5_a_at_rst", int'(a_out), 0);
        chk("t5_jam_at_rst", int'(jam), 0);
        tick();
        coin_a_raw = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (20) tick();
        chk("t5_a_count", na - na0, 0);

        // 6: long hold, then a b coin
        na0 = na; nb0 = nb; jam_edge = -1;
        coin_a_raw = 1'b1; t0 = cyc + 1;
        repeat (40) tick();
        coin_a_raw = 1'b0;
        repeat (15) tick();
        coin_b_raw = 1'b1;
        repeat (10) tick();
        coin_b_raw = 1'b0;
        repeat (20) tick();
        chk("t6_a_count", na - na0, 1);
        chk("t6_a_latency", ea - t0, 7);
`ifdef JAM_DETECT_EN
        chk("t6_jam_edge", jam_edge - t0, 26);
        chk("t6_b_count", nb - nb0, 0);
`else
        chk("t6_jam_edge", jam_edge, -1);
        chk("t6_b_count", nb - nb0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
